// File: rtl/uart_cmd_parser.sv
// Frames 4-byte "set duty" packets (sync, cmd, duty, csum) from the UART byte stream
// and holds one 8-bit duty register per PWM channel; bad or stalled packets are counted.
module uart_cmd_parser #(
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 5000,
  parameter logic [7:0] DUTY_RST    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [8*NUM_CH-1:0]   duty_bus,
  output logic                  duty_update,
  output logic [1:0]            upd_ch,
  output logic                  frame_err,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_CMD   = 2'd1,
    GET_DUTY  = 2'd2,
    GET_CSUM  = 2'd3
  } state_t;

  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  NUM_CH_L  = 3'(NUM_CH);

  state_t               state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           dbyte_q, dbyte_d;
  logic [23:0]          tmo_q, tmo_d;
  logic [8*NUM_CH-1:0]  duty_q, duty_d;
  logic                 upd_q, upd_d;
  logic [1:0]           ch_q, ch_d;
  logic                 ferr_q, ferr_d;
  logic [7:0]           err_q, err_d;
  logic                 pkt_ok;
  logic                 pkt_bad;

  // Packet check uses the latched CMD/DUTY and the CSUM byte arriving this cycle.
  assign pkt_ok = (cmd_q[7:4] == 4'h1) &&
                  (cmd_q[3:2] == 2'b00) &&
                  ({1'b0, cmd_q[1:0]} < NUM_CH_L) &&
                  (rx_data == (cmd_q ^ dbyte_q));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dbyte_d = dbyte_q;
    tmo_d   = tmo_q;
    duty_d  = duty_q;
    upd_d   = 1'b0;
    ch_d    = ch_q;
    ferr_d  = 1'b0;
    err_d   = err_q;
    pkt_bad = 1'b0;

    if (state_q == WAIT_SYNC) begin
      tmo_d = '0;
      if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = GET_CMD;
      end
    end else if (rx_valid) begin
      // A byte in the expiry cycle still counts; the timeout is simply dropped.
      tmo_d = '0;
      case (state_q)
        GET_CMD: begin
          cmd_d   = rx_data;
          state_d = GET_DUTY;
        end
        GET_DUTY: begin
          dbyte_d = rx_data;
          state_d = GET_CSUM;
        end
        default: begin
          state_d = WAIT_SYNC;
          if (pkt_ok) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (cmd_q[1:0] == 2'(k)) begin
                duty_d[8*k +: 8] = dbyte_q;
              end
            end
            ch_d  = cmd_q[1:0];
            upd_d = 1'b1;
          end else begin
            pkt_bad = 1'b1;
          end
        end
      endcase
    end else if (tmo_q == TMO_LAST) begin
      state_d = WAIT_SYNC;
      tmo_d   = '0;
      pkt_bad = 1'b1;
    end else begin
      tmo_d = tmo_q + 24'd1;
    end

    if (pkt_bad) begin
      ferr_d = 1'b1;
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SYNC;
      cmd_q   <= '0;
      dbyte_q <= '0;
      tmo_q   <= '0;
      duty_q  <= {NUM_CH{DUTY_RST}};
      upd_q   <= 1'b0;
      ch_q    <= '0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dbyte_q <= dbyte_d;
      tmo_q   <= tmo_d;
      duty_q  <= duty_d;
      upd_q   <= upd_d;
      ch_q    <= ch_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
    end
  end

  assign duty_bus    = duty_q;
  assign duty_update = upd_q;
  assign upd_ch      = ch_q;
  assign frame_err   = ferr_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser (3 channels, 16-cycle timeout): directed vector table,
// hand-written timeout/reset/saturation sequences, and random packets vs a packet-level model.
module tb_uart_cmd_parser;

  localparam int         NCH  = 3;
  localparam int         TMO  = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [8*NCH-1:0]  duty_bus;
  logic              duty_update;
  logic [1:0]        upd_ch;
  logic              frame_err;
  logic [7:0]        err_cnt;

  uart_cmd_parser #(
    .NUM_CH(NCH), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO), .DUTY_RST(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .duty_bus(duty_bus), .duty_update(duty_update), .upd_ch(upd_ch),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Packet-level reference model: collected bytes plus idle cycles since last byte.
  logic [7:0] m_duty [NCH];
  logic       m_upd;
  logic [1:0] m_ch;
  logic       m_ferr;
  logic [7:0] m_cnt;
  logic [7:0] pkt [$];
  int         idle;
  int         ferr_seen;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e_upd;
    logic       e_ferr;
  } vec_t;
  vec_t vecs [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) m_duty[k] = 8'h00;
    m_upd = 0; m_ch = 0; m_ferr = 0; m_cnt = 0; idle = 0;
    pkt.delete();
  endfunction

  function automatic void model_error();
    m_ferr = 1;
    if (m_cnt != 8'hFF) m_cnt++;
  endfunction

  function automatic void model_tick(input logic v, input logic [7:0] d);
    logic [7:0] cmd, dty;
    m_upd = 0;
    m_ferr = 0;
    if (v) begin
      idle = 0;
      if (pkt.size() > 0 || d == SYNC) pkt.push_back(d);
      if (pkt.size() == 4) begin
        cmd = pkt[1];
        dty = pkt[2];
        if ((cmd >> 4) == 8'h1 && (cmd & 8'h0C) == 0 && int'(cmd & 8'h03) < NCH &&
            pkt[3] == (cmd ^ dty)) begin
          m_duty[cmd & 8'h03] = dty;
          m_ch = cmd[1:0];
          m_upd = 1;
        end else begin
          model_error();
        end
        pkt.delete();
      end
    end else if (pkt.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        model_error();
        pkt.delete();
        idle = 0;
      end
    end
  endfunction

  function automatic logic [8*NCH-1:0] model_bus();
    logic [8*NCH-1:0] b;
    for (int k = 0; k < NCH; k++) b[8*k +: 8] = m_duty[k];
    return b;
  endfunction

  function automatic void compare_all();
    check("duty_bus", 32'(duty_bus), 32'(model_bus()));
    check("duty_update", 32'(duty_update), 32'(m_upd));
    check("upd_ch", 32'(upd_ch), 32'(m_ch));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_tick(v, d);
    #1;
    compare_all();
    if (frame_err) ferr_seen++;
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] dt, input logic [7:0] cs);
    step(1, SYNC); step(1, c); step(1, dt); step(1, cs);
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic eu, input logic ef);
    vec_t x;
    x.v = v; x.d = d; x.e_upd = eu; x.e_ferr = ef;
    vecs.push_back(x);
  endfunction

  initial begin
    rst_n = 0; rx_valid = 0; rx_data = 0;
    model_reset();

    // Directed table: expected pulse levels right after each vector's clock edge.
    add(1,8'hA5,0,0); add(1,8'h12,0,0); add(1,8'h80,0,0); add(1,8'h92,1,0); add(0,8'h00,0,0);
    add(1,8'hA5,0,0); add(1,8'h11,0,0); add(1,8'h40,0,0); add(1,8'h00,0,1); add(0,8'h00,0,0);
    add(1,8'hA5,0,0); add(1,8'h13,0,0); add(1,8'h10,0,0); add(1,8'h03,0,1);
    add(1,8'hA5,0,0); add(1,8'h22,0,0); add(1,8'h10,0,0); add(1,8'h32,0,1); add(0,8'h00,0,0);
    add(1,8'h00,0,0); add(1,8'hFF,0,0);
    add(1,8'hA5,0,0); add(1,8'h10,0,0); add(1,8'h33,0,0); add(1,8'h23,1,0);
    add(1,8'hA5,0,0); add(1,8'h11,0,0); add(1,8'h44,0,0); add(1,8'h55,1,0); add(0,8'h00,0,0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_duty_bus", 32'(duty_bus), 32'h0);
    check("rst_duty_update", 32'(duty_update), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_upd_ch", 32'(upd_ch), 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d);
      check("vec_update", 32'(duty_update), 32'(vecs[i].e_upd));
      check("vec_frame_err", 32'(frame_err), 32'(vecs[i].e_ferr));
      $display("vec %0d: v=%0b d=%02h upd=%0b ferr=%0b err_cnt=%0d",
               i, vecs[i].v, vecs[i].d, duty_update, frame_err, err_cnt);
      if (i == 3) begin
        check("pkt1_bus", 32'(duty_bus), 32'h800000);
        check("pkt1_ch", 32'(upd_ch), 32'h2);
      end
    end
    check("table_bus", 32'(duty_bus), 32'h804433);
    check("table_err_cnt", 32'(err_cnt), 32'd3);

    // Stall after CMD: exactly one timeout error, then a clean packet.
    ferr_seen = 0;
    step(1, SYNC); step(1, 8'h10);
    repeat (20) step(0, 8'h00);
    check("tmo_pulses", 32'(ferr_seen), 32'd1);
    check("tmo_err_cnt", 32'(err_cnt), 32'd4);
    send_pkt(8'h10, 8'h07, 8'h17);
    check("after_tmo_bus", 32'(duty_bus), 32'h804407);
    $display("timeout sequence: err_cnt=%0d duty_bus=%06h", err_cnt, duty_bus);

    // Byte lands on the very cycle the idle counter would expire.
    ferr_seen = 0;
    step(1, SYNC); step(1, 8'h10);
    repeat (TMO - 1) step(0, 8'h00);
    step(1, 8'h08); step(1, 8'h18);
    check("expiry_upd", 32'(duty_update), 32'h1);
    check("expiry_pulses", 32'(ferr_seen), 32'd0);
    check("expiry_bus", 32'(duty_bus), 32'h804408);
    $display("expiry-cycle byte: duty_update=%0b duty_bus=%06h", duty_update, duty_bus);

    // Asynchronous reset in the middle of a packet.
    step(1, SYNC); step(1, 8'h10);
    rx_valid = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check("mid_rst_bus", 32'(duty_bus), 32'h0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    check("mid_rst_upd", 32'(duty_update), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send_pkt(8'h12, 8'h55, 8'h47);
    check("post_rst_bus", 32'(duty_bus), 32'h550000);
    $display("reset sequence: duty_bus=%06h err_cnt=%0d", duty_bus, err_cnt);

    // Saturation of the error counter; frame_err keeps pulsing.
    ferr_seen = 0;
    for (int p = 0; p < 260; p++) send_pkt(8'h11, 8'h40, 8'h00);
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
    check("sat_pulses", 32'(ferr_seen), 32'd260);
    $display("saturation: err_cnt=%02h pulses=%0d", err_cnt, ferr_seen);

    // Random packets, garbage and gaps against the model.
    for (int p = 0; p < 300; p++) begin
      logic [7:0] c, dt, cs;
      int kind;
      repeat ($urandom_range(0, 2)) step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      kind = $urandom_range(0, 5);
      c  = 8'h10 | 8'($urandom_range(0, 3));
      dt = 8'($urandom_range(0, 255));
      if (kind == 0) c = 8'($urandom_range(0, 255));
      cs = c ^ dt;
      if (kind == 1) cs = cs ^ 8'($urandom_range(1, 255));
      step(1, SYNC);
      for (int b = 0; b < 3; b++) begin
        int gap;
        gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 2);
        repeat (gap) step(0, 8'h00);
        step(1, (b == 0) ? c : (b == 1) ? dt : cs);
      end
      $display("rand pkt %0d: cmd=%02h duty=%02h csum=%02h upd=%0b ferr=%0b",
               p, c, dt, cs, duty_update, frame_err);
    end
    repeat (TMO + 2) step(0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule
